// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with busy-bit scoreboard and write-to-read forwarding
module reg_file_sb #(
    parameter  int DATA_WIDTH = 16,
    parameter  int NUM_REGS   = 8,
    parameter  int ZERO_REG   = 1,
    parameter  int BYPASS     = 1,
    localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wrEn,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic [DATA_WIDTH-1:0] dIn,
    input  logic                  issueEn,
    input  logic [ADDR_WIDTH-1:0] issueRd,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic [DATA_WIDTH-1:0] r1,
    output logic [DATA_WIDTH-1:0] r2,
    output logic                  r1Valid,
    output logic                  r2Valid,
    output logic [NUM_REGS-1:0]   busyMask
);

    logic [DATA_WIDTH-1:0] mem [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_nxt;
    logic                  wr_ok;
    logic                  iss_ok;
    logic                  fwd1, fwd2;
    logic                  zero1, zero2;

    assign wr_ok  = wrEn && !((ZERO_REG != 0) && (rd == '0));
    assign iss_ok = issueEn && !((ZERO_REG != 0) && (issueRd == '0));

    // Issue is applied after writeback so a new producer keeps the register busy.
    always_comb begin
        busy_nxt = busy;
        if (wrEn)
            busy_nxt[rd] = 1'b0;
        if (iss_ok)
            busy_nxt[issueRd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                mem[i] <= '0;
            busy <= '0;
        end else begin
            if (wr_ok)
                mem[rd] <= dIn;
            busy <= busy_nxt;
        end
    end

    assign fwd1  = (BYPASS != 0) && !rst && wr_ok && (rd == rs1);
    assign fwd2  = (BYPASS != 0) && !rst && wr_ok && (rd == rs2);
    assign zero1 = (ZERO_REG != 0) && (rs1 == '0);
    assign zero2 = (ZERO_REG != 0) && (rs2 == '0);

    always_comb begin
        r1 = mem[rs1];
        if (zero1)
            r1 = '0;
        else if (fwd1)
            r1 = dIn;
        r2 = mem[rs2];
        if (zero2)
            r2 = '0;
        else if (fwd2)
            r2 = dIn;
    end

    assign r1Valid  = zero1 || fwd1 || !busy[rs1];
    assign r2Valid  = zero2 || fwd2 || !busy[rs2];
    assign busyMask = busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - randomized bench with behavioural model for reg_file_sb (default and no-zero/no-bypass builds)
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst, wrEn, issueEn;
    logic [2:0]  rd, issueRd, rs1, rs2;
    logic [15:0] dIn;
    logic [15:0] r1_a, r2_a, r1_b, r2_b;
    logic        r1v_a, r2v_a, r1v_b, r2v_b;
    logic [7:0]  bm_a, bm_b;

    int passed = 0;
    int total  = 0;
    bit started = 0;

    logic [15:0] mem_m  [2][8];
    bit          busy_m [2][8];
    bit          zr [2] = '{1'b1, 1'b0};
    bit          bp [2] = '{1'b1, 1'b0};

    always #5 clk = ~clk;

    reg_file_sb dut_a (
        .clk(clk), .rst(rst), .wrEn(wrEn), .rd(rd), .dIn(dIn),
        .issueEn(issueEn), .issueRd(issueRd), .rs1(rs1), .rs2(rs2),
        .r1(r1_a), .r2(r2_a), .r1Valid(r1v_a), .r2Valid(r2v_a), .busyMask(bm_a)
    );

    reg_file_sb #(.ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .wrEn(wrEn), .rd(rd), .dIn(dIn),
        .issueEn(issueEn), .issueRd(issueRd), .rs1(rs1), .rs2(rs2),
        .r1(r1_b), .r2(r2_b), .r1Valid(r1v_b), .r2Valid(r2v_b), .busyMask(bm_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else
            passed++;
    endtask

    // Architectural state: a write lands unless it targets a hardwired zero;
    // writeback retires the pending result, then a new issue marks it pending again.
    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                for (int i = 0; i < 8; i++) begin
                    mem_m[c][i]  = '0;
                    busy_m[c][i] = 0;
                end
            end else begin
                if (wrEn) begin
                    if (!(zr[c] && rd == 0))
                        mem_m[c][rd] = dIn;
                    busy_m[c][rd] = 0;
                end
                if (issueEn && !(zr[c] && issueRd == 0))
                    busy_m[c][issueRd] = 1;
            end
        end
        if (rst)
            started = 1;
    end

    function automatic void exp_read(input int c, input logic [2:0] idx,
                                     output logic [15:0] d, output logic v);
        if (zr[c] && idx == 0) begin
            d = '0; v = 1'b1;
        end else if (bp[c] && wrEn && !rst && rd == idx) begin
            d = dIn; v = 1'b1;
        end else begin
            d = mem_m[c][idx]; v = !busy_m[c][idx];
        end
    endfunction

    function automatic logic [7:0] exp_mask(input int c);
        logic [7:0] m;
        for (int i = 0; i < 8; i++)
            m[i] = busy_m[c][i];
        return m;
    endfunction

    always @(negedge clk) begin
        logic [15:0] d;
        logic        v;
        if (started) begin
            exp_read(0, rs1, d, v); chk("a_r1", r1_a, d); chk("a_r1v", r1v_a, v);
            exp_read(0, rs2, d, v); chk("a_r2", r2_a, d); chk("a_r2v", r2v_a, v);
            exp_read(1, rs1, d, v); chk("b_r1", r1_b, d); chk("b_r1v", r1v_b, v);
            exp_read(1, rs2, d, v); chk("b_r2", r2_b, d); chk("b_r2v", r2v_b, v);
            chk("a_mask", bm_a, exp_mask(0));
            chk("b_mask", bm_b, exp_mask(1));
        end
    end

    task automatic drive(input logic r, input logic we, input logic [2:0] a_rd, input logic [15:0] d,
                         input logic ie, input logic [2:0] a_ird, input logic [2:0] a1, input logic [2:0] a2);
        rst = r; wrEn = we; rd = a_rd; dIn = d; issueEn = ie; issueRd = a_ird; rs1 = a1; rs2 = a2;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1, 1, 3, 16'hFFFF, 1, 3, 0, 0);
        tick();
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset contents: every index reads zero and valid
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0, 0, 0, 3'(i), 3'(7 - i));
            chk("rst_r1", r1_a, 16'h0); chk("rst_r1v", r1v_a, 1'b1);
            chk("rst_r2", r2_a, 16'h0); chk("rst_r2v", r2v_a, 1'b1);
            chk("rst_b_r1", r1_b, 16'h0);
        end
        chk("rst_mask", bm_a, 8'h00);
        tick();

        // Same-cycle forwarding vs registered visibility
        drive(0, 1, 3, 16'hBEEF, 0, 0, 3, 3);
        chk("byp_r1", r1_a, 16'hBEEF);
        chk("byp_r2", r2_a, 16'hBEEF);
        chk("nobyp_r1", r1_b, 16'h0000);
        tick();
        drive(0, 0, 3, 16'h0, 0, 0, 3, 0);
        chk("after_r1", r1_a, 16'hBEEF);
        chk("after_b_r1", r1_b, 16'hBEEF);
        tick();

        // Register 0 hardwired in build A, ordinary in build B
        drive(0, 1, 0, 16'h1234, 0, 0, 1, 0);
        chk("z_fwd_r2", r2_a, 16'h0000);
        tick();
        drive(0, 0, 0, 16'h0, 0, 0, 1, 0);
        chk("z_r2", r2_a, 16'h0000); chk("z_r2v", r2v_a, 1'b1);
        chk("nz_r2", r2_b, 16'h1234);
        tick();

        // Scoreboard set, forwarded completion, clear
        drive(0, 0, 0, 16'h0, 1, 5, 0, 0);
        tick();
        drive(0, 0, 0, 16'h0, 0, 0, 5, 5);
        chk("busy_r1v", r1v_a, 1'b0); chk("busy_mask", bm_a, 8'h20);
        tick();
        drive(0, 1, 5, 16'h00AA, 0, 0, 5, 5);
        chk("wb_r1", r1_a, 16'h00AA); chk("wb_r1v", r1v_a, 1'b1);
        chk("wb_b_r1v", r1v_b, 1'b0);
        tick();
        drive(0, 0, 0, 16'h0, 0, 0, 5, 5);
        chk("clr_mask", bm_a, 8'h00); chk("clr_r1", r1_a, 16'h00AA);
        tick();

        // Issue and writeback to the same register: data lands, stays busy
        drive(0, 1, 2, 16'h0011, 1, 2, 0, 0);
        tick();
        drive(0, 0, 0, 16'h0, 0, 0, 2, 0);
        chk("same_r1", r1_a, 16'h0011); chk("same_r1v", r1v_a, 1'b0);
        chk("same_mask", bm_a, 8'h04);
        tick();

        // Issue and writeback to different registers
        drive(0, 1, 2, 16'h0022, 1, 6, 2, 6);
        tick();
        drive(0, 0, 0, 16'h0, 0, 0, 2, 6);
        chk("diff_mask", bm_a, 8'h40);
        chk("diff_r1v", r1v_a, 1'b1); chk("diff_r2v", r2v_a, 1'b0);
        tick();

        // Reset clears busy bits and contents; writes during reset are dropped
        drive(0, 1, 4, 16'h0F0F, 1, 4, 0, 0);
        tick();
        drive(1, 1, 4, 16'hFFFF, 1, 7, 4, 4);
        chk("inrst_r1", r1_a, 16'h0F0F); chk("inrst_r1v", r1v_a, 1'b0);
        tick();
        drive(0, 0, 0, 16'h0, 0, 0, 4, 4);
        chk("postrst_mask", bm_a, 8'h00); chk("postrst_r1", r1_a, 16'h0000);
        chk("postrst_r1v", r1v_a, 1'b1);
        tick();
        drive(0, 1, 4, 16'h5555, 0, 0, 1, 1);
        tick();
        drive(0, 0, 0, 16'h0, 0, 0, 4, 4);
        chk("rewrite_r1", r1_a, 16'h5555);
        tick();

        for (int n = 0; n < 3000; n++) begin
            logic [2:0] w, a1, a2;
            w  = 3'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 2) == 0) ? w : 3'($urandom_range(0, 7));
            a2 = ($urandom_range(0, 2) == 0) ? w : 3'($urandom_range(0, 7));
            drive(($urandom_range(0, 60) == 0), 1'($urandom_range(0, 1)), w, 16'($urandom),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? w : 3'($urandom_range(0, 7)),
                  a1, a2);
            tick();
        end

        drive(0, 0, 0, 16'h0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
